start_sequencer: RTL

Synthesizable initiator for the program Start/Done handshake of the processor core. The block drives the core's Start input with one pulse per program, waits for the core's Done, then moves to the next program until NPROG programs have run. It sits between the on-board run control (Go) and the core. The core's program counter counts Start rising edges and jumps to the program entry on each Start falling edge.

---
 rtl/start_seq_pkg.sv | 19 +
 rtl/seq_run_ctr.sv | 40 ++++
 rtl/start_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/start_seq_pkg.sv
// start_seq_pkg: shared types and defaults for the program Start/Done sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package start_seq_pkg;

  localparam int NPROG_DEF    = 3;
  localparam int START_HI_DEF = 2;
  localparam int TMO_W_DEF    = 16;
  localparam int PIDX_W       = 2;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    RUN,
    GAP,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/seq_run_ctr.sv
// seq_run_ctr: W-bit run-cycle counter; clear loads 1 so the first counted cycle reads 1.
// Latency: count visible the cycle after clear/enable; all-ones flag is combinational from the count.
// Backpressure: none; enable simply holds the value when low.
module seq_run_ctr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         all_ones_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear reloads 1, enable increments, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign all_ones_o = &cnt_q;

endmodule

// File: rtl/start_sequencer.sv
// start_sequencer: pulses the core Start once per program and waits for Done, NPROG programs per Go edge.
// Latency: Start rises the cycle after an accepted Go edge; CycleCount/CountValid one cycle after Done in RUN.
// Backpressure: Go edges while Busy are dropped; a timeout ends the sequence. Optional macro START_SEQ_COUNT_EN enables CycleCount/CountValid.
module start_sequencer
  import start_seq_pkg::*;
#(
  parameter int NPROG    = NPROG_DEF,
  parameter int START_HI = START_HI_DEF,
  parameter int TMO_W    = TMO_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic              Done,
  output logic              Start,
  output logic [PIDX_W-1:0] ProgIdx,
  output logic              Busy,
  output logic              AllDone,
  output logic              TimedOut,
  output logic [TMO_W-1:0]  CycleCount,
  output logic              CountValid
);

  localparam int HOLD_W = (START_HI < 2) ? 1 : $clog2(START_HI);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HI - 1);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(NPROG - 1);

  seq_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic              go_q;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              tmo_q, tmo_d;
  logic [TMO_W-1:0]  cyc_q, cyc_d;
  logic              cv_q, cv_d;

  logic              ctr_clr;
  logic              ctr_en;
  logic [TMO_W-1:0]  run_cnt;
  logic              run_all_ones;

  seq_run_ctr #(
    .W(TMO_W)
  ) u_run_ctr (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .clr_i      (ctr_clr),
    .en_i       (ctr_en),
    .cnt_o      (run_cnt),
    .all_ones_o (run_all_ones)
  );

`ifndef START_SEQ_COUNT_EN
  // Without the cycle report the count value itself only feeds the timeout flag.
  logic [TMO_W-1:0] unused_run_cnt;
  assign unused_run_cnt = run_cnt;
`endif

  // Next-state and next-output logic; Start/Busy are derived from the next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pidx_d     = pidx_q;
    all_done_d = all_done_q;
    tmo_d      = tmo_q;
    cyc_d      = cyc_q;
    cv_d       = 1'b0;
    ctr_clr    = 1'b1;
    ctr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Go && !go_q) begin
          state_d    = ASSERT;
          hold_d     = '0;
          pidx_d     = '0;
          all_done_d = 1'b0;
          tmo_d      = 1'b0;
        end
      end
      ASSERT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        ctr_clr = 1'b0;
        ctr_en  = 1'b1;
        // Done takes priority over a simultaneous timeout.
        if (Done) begin
`ifdef START_SEQ_COUNT_EN
          cyc_d = run_cnt;
          cv_d  = 1'b1;
`endif
          if (pidx_q == PIDX_LAST) begin
            state_d = FINISH;
          end else begin
            pidx_d  = pidx_q + PIDX_W'(1);
            state_d = GAP;
          end
        end else if (run_all_ones) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
        end
      end
      GAP: begin
        state_d = ASSERT;
      end
      FINISH: begin
        all_done_d = !tmo_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_d = (state_d == ASSERT);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything asynchronously so Start cannot stay high.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      pidx_q     <= '0;
      go_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      tmo_q      <= 1'b0;
      cyc_q      <= '0;
      cv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pidx_q     <= pidx_d;
      go_q       <= Go;
      start_q    <= start_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      tmo_q      <= tmo_d;
      cyc_q      <= cyc_d;
      cv_q       <= cv_d;
    end
  end

  assign Start      = start_q;
  assign ProgIdx    = pidx_q;
  assign Busy       = busy_q;
  assign AllDone    = all_done_q;
  assign TimedOut   = tmo_q;
  assign CycleCount = cyc_q;
  assign CountValid = cv_q;

endmodule
